mips_cp0: RTL and testbench

MIPS-style coprocessor 0 for the 64-bit pipeline's MEM stage. It holds the Status, Cause, EPC and PRId registers and services MTC0/MFC0. It detects exceptions and interrupts, and asserts takenHandler so the pipeline redirects to the handler. ERET ends handler mode.

---
 rtl/mips_cp0.sv | 114 +++++++++++
 tb/tb_mips_cp0.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cp0.sv
// MIPS-style coprocessor 0 for the 64-bit pipeline's MEM stage.
// Holds Status/Cause/EPC/PRId, services MTC0/MFC0 and accepts exceptions and interrupts.
module mips_cp0 #(
    parameter logic [63:0] PRID = 64'h0000_0000_0001_8000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [63:0] rd_data,
    output logic [63:0] EPC,
    output logic        takenHandler,
    input  logic [63:0] wr_data,
    input  logic [4:0]  regnum,
    input  logic [2:0]  sel,
    input  logic [63:0] curr_pc,
    input  logic        MTC0,
    input  logic        ERET,
    input  logic [7:0]  interrupt_source,
    input  logic        overflow,
    input  logic        reserved_inst,
    input  logic        syscall,
    input  logic        break_
);

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] REG_PRID   = 5'd15;

    logic        ie_r;
    logic        exl_r;
    logic [7:0]  im_r;
    logic [4:0]  exc_code_r;
    logic [63:0] epc_r;

    logic        exc_s;
    logic        intr_s;
    logic        taken_s;
    logic [4:0]  code_s;
    logic [63:0] status_s;
    logic [63:0] cause_s;

    assign exc_s        = reserved_inst | syscall | break_ | overflow;
    assign intr_s       = ie_r & (|(interrupt_source & im_r));
    assign taken_s      = ~exl_r & (exc_s | intr_s);
    assign takenHandler = taken_s;
    assign EPC          = epc_r;

    assign status_s = {48'h0, im_r, 6'h0, exl_r, ie_r};
    assign cause_s  = {48'h0, interrupt_source, 1'b0, exc_code_r, 2'b00};

    // Exception code selection, highest-priority source first
    always_comb begin
        code_s = 5'd0;
        if (reserved_inst) begin
            code_s = 5'd10;
        end else if (syscall) begin
            code_s = 5'd8;
        end else if (break_) begin
            code_s = 5'd9;
        end else if (overflow) begin
            code_s = 5'd12;
        end else begin
            code_s = 5'd0;
        end
    end

    // MFC0 read mux; only sel 0 addresses real registers
    always_comb begin
        rd_data = 64'h0;
        if (sel == 3'd0) begin
            case (regnum)
                REG_STATUS: rd_data = status_s;
                REG_CAUSE:  rd_data = cause_s;
                REG_EPC:    rd_data = epc_r;
                REG_PRID:   rd_data = PRID;
                default:    rd_data = 64'h0;
            endcase
        end else begin
            rd_data = 64'h0;
        end
    end

    // Register state: handler entry beats ERET, which beats a plain MTC0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ie_r       <= 1'b0;
            exl_r      <= 1'b0;
            im_r       <= 8'h0;
            exc_code_r <= 5'd0;
            epc_r      <= 64'h0;
        end else if (taken_s) begin
            epc_r      <= curr_pc;
            exl_r      <= 1'b1;
            exc_code_r <= code_s;
        end else begin
            if (MTC0 && (sel == 3'd0)) begin
                case (regnum)
                    REG_STATUS: begin
                        ie_r  <= wr_data[0];
                        exl_r <= wr_data[1];
                        im_r  <= wr_data[15:8];
                    end
                    REG_EPC: epc_r <= wr_data;
                    default: ;
                endcase
            end
            // Placed after the MTC0 update so ERET overrides a written EXL bit
            if (ERET) begin
                exl_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_cp0.sv
// Scoreboard bench for mips_cp0: driver pushes model expectations, monitor pops
// and compares them against the DUT on the falling edge.
module tb_mips_cp0;

    localparam logic [63:0] PRID_V = 64'h0000_0000_0001_8000;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] rd_data, EPC;
    logic        takenHandler;
    logic [63:0] wr_data, curr_pc;
    logic [4:0]  regnum;
    logic [2:0]  sel;
    logic        MTC0, ERET, overflow, reserved_inst, syscall, break_;
    logic [7:0]  interrupt_source;

    mips_cp0 #(.PRID(PRID_V)) dut (
        .clock(clock), .reset(reset), .rd_data(rd_data), .EPC(EPC),
        .takenHandler(takenHandler), .wr_data(wr_data), .regnum(regnum), .sel(sel),
        .curr_pc(curr_pc), .MTC0(MTC0), .ERET(ERET), .interrupt_source(interrupt_source),
        .overflow(overflow), .reserved_inst(reserved_inst), .syscall(syscall), .break_(break_)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [63:0] rd;
        logic [63:0] epc;
        logic        taken;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: architectural view only
    logic [63:0] m_status;
    int          m_code;
    logic [63:0] m_epc;

    function automatic bit m_taken();
        bit exc, intr;
        exc  = reserved_inst || syscall || break_ || overflow;
        intr = m_status[0] && ((interrupt_source & m_status[15:8]) != 8'h0);
        return !m_status[1] && (exc || intr);
    endfunction

    function automatic int m_prio();
        if (reserved_inst) return 10;
        if (syscall)       return 8;
        if (break_)        return 9;
        if (overflow)      return 12;
        return 0;
    endfunction

    function automatic logic [63:0] m_read();
        logic [63:0] c;
        if (sel != 3'd0) return 64'h0;
        case (regnum)
            5'd12: return m_status;
            5'd13: begin
                c = 64'h0;
                c[15:8] = interrupt_source;
                c = c + 64'(m_code * 4);
                return c;
            end
            5'd14: return m_epc;
            5'd15: return PRID_V;
            default: return 64'h0;
        endcase
    endfunction

    task automatic m_clear();
        m_status = 64'h0;
        m_code   = 0;
        m_epc    = 64'h0;
    endtask

    task automatic m_edge();
        if (reset) begin
            m_clear();
        end else if (m_taken()) begin
            m_epc       = curr_pc;
            m_status[1] = 1'b1;
            m_code      = m_prio();
        end else begin
            if (MTC0 && sel == 3'd0) begin
                if (regnum == 5'd12) m_status = wr_data & 64'hFF03;
                else if (regnum == 5'd14) m_epc = wr_data;
            end
            if (ERET) m_status[1] = 1'b0;
        end
    endtask

    task automatic idle();
        wr_data = 64'h0; curr_pc = 64'h0; regnum = 5'd0; sel = 3'd0;
        MTC0 = 1'b0; ERET = 1'b0; overflow = 1'b0; reserved_inst = 1'b0;
        syscall = 1'b0; break_ = 1'b0; interrupt_source = 8'h0;
    endtask

    // Inputs are already applied; record the expected view, then clock the model
    task automatic cycle(input string name);
        exp_t e;
        if (reset) m_clear();
        e.name  = name;
        e.rd    = m_read();
        e.epc   = m_epc;
        e.taken = m_taken();
        exp_q.push_back(e);
        @(posedge clock);
        m_edge();
        #1;
    endtask

    task automatic chk(input string name, input string what, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", name, what, act, req);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "rd_data", rd_data, e.rd);
                chk(e.name, "EPC", EPC, e.epc);
                chk(e.name, "takenHandler", {63'h0, takenHandler}, {63'h0, e.taken});
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1'b1;
        m_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        regnum = 5'd12; cycle("rst_status");
        regnum = 5'd13; cycle("rst_cause");
        regnum = 5'd14; cycle("rst_epc");
        regnum = 5'd15; cycle("prid");
        regnum = 5'd12; sel = 3'd1; cycle("status_sel1");
        sel = 3'd0;

        MTC0 = 1'b1; regnum = 5'd12; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; cycle("wr_status_ones");
        MTC0 = 1'b0; cycle("rd_status_ff03");
        MTC0 = 1'b1; regnum = 5'd14; wr_data = 64'h1234_5678_9ABC_DEF0; cycle("wr_epc");
        MTC0 = 1'b0; cycle("rd_epc");

        MTC0 = 1'b1; regnum = 5'd12; wr_data = 64'h0401; cycle("wr_status_0401");
        MTC0 = 1'b0; interrupt_source = 8'h04; curr_pc = 64'h40_0010; cycle("intr_taken");
        regnum = 5'd13; cycle("intr_cause");
        regnum = 5'd12; cycle("intr_status");
        regnum = 5'd14; cycle("intr_epc");

        ERET = 1'b1; cycle("eret");
        ERET = 1'b0; curr_pc = 64'h40_0020; cycle("intr_reassert");
        interrupt_source = 8'h00;
        MTC0 = 1'b1; regnum = 5'd12; wr_data = 64'h0; cycle("clr_status");
        MTC0 = 1'b0;

        reserved_inst = 1'b1; overflow = 1'b1; curr_pc = 64'h80_0000; regnum = 5'd13; cycle("ri_ov");
        reserved_inst = 1'b0; overflow = 1'b0; syscall = 1'b1; curr_pc = 64'h90_0000; cycle("sys_masked");
        syscall = 1'b0; regnum = 5'd12; cycle("exl_set");
        ERET = 1'b1; MTC0 = 1'b1; wr_data = 64'hFF03; cycle("eret_mtc0_status");
        ERET = 1'b0; MTC0 = 1'b0; cycle("exl_overridden");

        break_ = 1'b1; MTC0 = 1'b1; regnum = 5'd14; wr_data = 64'hDEAD_BEEF; curr_pc = 64'hA0_0000;
        cycle("exc_vs_mtc0");
        idle(); regnum = 5'd14; cycle("epc_exc_wins");
        regnum = 5'd13; cycle("break_code");

        regnum = 5'd12; reset = 1'b1; cycle("async_reset");
        reset = 1'b0; cycle("after_reset");

        for (int i = 0; i < 400; i++) begin
            int pick;
            idle();
            pick = $urandom_range(5);
            regnum = (pick < 4) ? 5'(12 + pick) : 5'($urandom_range(31));
            sel = ($urandom_range(7) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
            wr_data = {$urandom, $urandom};
            curr_pc = {$urandom, $urandom};
            MTC0 = ($urandom_range(2) == 0);
            ERET = ($urandom_range(5) == 0);
            interrupt_source = 8'($urandom_range(255));
            overflow = ($urandom_range(15) == 0);
            reserved_inst = ($urandom_range(15) == 0);
            syscall = ($urandom_range(15) == 0);
            break_ = ($urandom_range(15) == 0);
            reset = ($urandom_range(49) == 0);
            cycle("random");
        end
        reset = 1'b0; idle();

        @(negedge clock);
        #1;
        chk("drain", "pending", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
